// File: rtl/crossbar_rr.sv
// N_IN x N_OUT crossbar with per-input FIFOs, registered outputs and a
// round-robin arbiter per output; heads with an out-of-range dest are dropped.
module crossbar_rr #(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned N_OUT      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DEST_BITS  = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    parameter int unsigned SRC_BITS   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [N_IN-1:0]                     in_valid,
    input  logic [N_IN-1:0][DATA_WIDTH-1:0]     in_data,
    input  logic [N_IN-1:0][DEST_BITS-1:0]      in_dest,
    output logic [N_IN-1:0]                     in_ready,
    output logic [N_OUT-1:0]                    out_valid,
    output logic [N_OUT-1:0][DATA_WIDTH-1:0]    out_data,
    output logic [N_OUT-1:0][SRC_BITS-1:0]      out_src,
    input  logic [N_OUT-1:0]                    out_ready,
    output logic                                stall,
    output logic                                dest_err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0]            mem_data_q [N_IN][FIFO_DEPTH];
    logic [DEST_BITS-1:0]             mem_dest_q [N_IN][FIFO_DEPTH];
    logic [PTR_W-1:0]                 wr_ptr_q [N_IN];
    logic [PTR_W-1:0]                 wr_ptr_d [N_IN];
    logic [PTR_W-1:0]                 rd_ptr_q [N_IN];
    logic [PTR_W-1:0]                 rd_ptr_d [N_IN];
    logic [CNT_W-1:0]                 count_q  [N_IN];
    logic [CNT_W-1:0]                 count_d  [N_IN];
    logic [SRC_BITS-1:0]              rr_ptr_q [N_OUT];
    logic [SRC_BITS-1:0]              rr_ptr_d [N_OUT];
    logic [N_OUT-1:0]                 out_valid_q, out_valid_d;
    logic [N_OUT-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [N_OUT-1:0][SRC_BITS-1:0]   out_src_q, out_src_d;
    logic                             dest_err_q, dest_err_d;

    logic [N_IN-1:0]                  full, empty, push, pop, head_bad;
    logic [DATA_WIDTH-1:0]            head_data [N_IN];
    logic [DEST_BITS-1:0]             head_dest [N_IN];
    logic [N_OUT-1:0]                 out_free, gnt_vld;
    logic [SRC_BITS-1:0]              gnt_idx [N_OUT];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // FIFO status, head decode and input acceptance
    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            full[i]      = (count_q[i] == CNT_W'(FIFO_DEPTH));
            empty[i]     = (count_q[i] == '0);
            head_data[i] = mem_data_q[i][rd_ptr_q[i]];
            head_dest[i] = mem_dest_q[i][rd_ptr_q[i]];
            head_bad[i]  = !empty[i] && (32'(head_dest[i]) >= N_OUT);
            in_ready[i]  = !full[i] && !RST;
            push[i]      = in_valid[i] && in_ready[i];
        end
    end

    assign stall = |(in_valid & ~in_ready);

    // Per-output round-robin search starting at rr_ptr, only when output is free
    always_comb begin
        int unsigned         idx;
        logic [SRC_BITS-1:0] sel;
        idx     = 0;
        sel     = '0;
        gnt_vld = '0;
        pop     = head_bad;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            gnt_idx[j]  = '0;
            out_free[j] = !out_valid_q[j] || out_ready[j];
            for (int unsigned k = 0; k < N_IN; k++) begin
                idx = 32'(rr_ptr_q[j]) + k;
                if (idx >= N_IN) begin
                    idx = idx - N_IN;
                end
                sel = SRC_BITS'(idx);
                if (out_free[j] && !gnt_vld[j] && !empty[sel] &&
                    (32'(head_dest[sel]) == j)) begin
                    gnt_vld[j] = 1'b1;
                    gnt_idx[j] = sel;
                    pop[sel]   = 1'b1;
                end
            end
        end
    end

    // Next-state for FIFO bookkeeping, output registers and arbiter pointers
    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            rr_ptr_d[j] = rr_ptr_q[j];
            if (gnt_vld[j]) begin
                out_valid_d[j] = 1'b1;
                out_data_d[j]  = head_data[gnt_idx[j]];
                out_src_d[j]   = gnt_idx[j];
                rr_ptr_d[j]    = (gnt_idx[j] == SRC_BITS'(N_IN - 1)) ? '0
                                                                    : gnt_idx[j] + SRC_BITS'(1);
            end else if (out_ready[j]) begin
                out_valid_d[j] = 1'b0;
            end
        end
        dest_err_d = dest_err_q || (|head_bad);
    end

    // State registers; FIFO storage is written without reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            for (int unsigned j = 0; j < N_OUT; j++) begin
                rr_ptr_q[j] <= '0;
            end
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            dest_err_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (push[i]) begin
                    mem_data_q[i][wr_ptr_q[i]] <= in_data[i];
                    mem_dest_q[i][wr_ptr_q[i]] <= in_dest[i];
                end
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            for (int unsigned j = 0; j < N_OUT; j++) begin
                rr_ptr_q[j] <= rr_ptr_d[j];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            dest_err_q  <= dest_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign dest_err  = dest_err_q;

endmodule

// File: tb/tb_crossbar_rr.sv
// Directed bench for crossbar_rr: a 4x4 instance plus a 4x3 instance for the
// invalid-destination path.
module tb_crossbar_rr;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic             RST;
    logic [3:0]       in_valid, in_ready, out_valid, out_ready;
    logic [3:0][31:0] in_data, out_data;
    logic [3:0][1:0]  in_dest, out_src;
    logic             stall, dest_err;

    logic             b_rst;
    logic [3:0]       b_in_valid, b_in_ready;
    logic [3:0][31:0] b_in_data;
    logic [3:0][1:0]  b_in_dest;
    logic [2:0]       b_out_valid, b_out_ready;
    logic [2:0][31:0] b_out_data;
    logic [2:0][1:0]  b_out_src;
    logic             b_stall, b_dest_err;

    int n_checks = 0;
    int n_pass   = 0;

    crossbar_rr dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
        .stall(stall), .dest_err(dest_err)
    );

    crossbar_rr #(.N_IN(4), .N_OUT(3)) dut3 (
        .CLK(CLK), .RST(b_rst),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_dest(b_in_dest), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_src(b_out_src), .out_ready(b_out_ready),
        .stall(b_stall), .dest_err(b_dest_err)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1; b_rst = 1'b1; in_valid = '0; b_in_valid = '0;
        tick();
        RST = 1'b0; b_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; b_rst = 1'b1;
        tick(); tick();
        n_checks++; if (out_valid !== 4'h0) $display("FAIL reset_out_valid: got %h want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_src !== '0) $display("FAIL reset_out_src: got %h want 0", out_src); else n_pass++;
        n_checks++; if (dest_err !== 1'b0) $display("FAIL reset_dest_err: got %b want 0", dest_err); else n_pass++;
        n_checks++; if (in_ready !== 4'h0) $display("FAIL reset_in_ready_during: got %h want 0", in_ready); else n_pass++;
        n_checks++; if (b_in_ready !== 4'h0) $display("FAIL reset_b_in_ready_during: got %h want 0", b_in_ready); else n_pass++;
        RST = 1'b0; b_rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 4'hF) $display("FAIL reset_in_ready_after: got %h want f", in_ready); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
    endtask

    task automatic test_single_path;
        out_ready = 4'hF;
        in_valid = 4'b0100; in_data[2] = 32'hDEADBEEF; in_dest[2] = 2'd1;
        tick();
        in_valid = '0;
        n_checks++; if (out_valid !== 4'h0) $display("FAIL single_early: got %h want 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 4'b0010) $display("FAIL single_valid: got %h want 2", out_valid); else n_pass++;
        n_checks++; if (out_data[1] !== 32'hDEADBEEF) $display("FAIL single_data: got %h want deadbeef", out_data[1]); else n_pass++;
        n_checks++; if (out_src[1] !== 2'd2) $display("FAIL single_src: got %0d want 2", out_src[1]); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 4'h0) $display("FAIL single_drained: got %h want 0", out_valid); else n_pass++;
    endtask

    task automatic test_fairness;
        logic [3:0] rdy;
        int         acc [4];
        int         gcnt [4];
        int         g;
        int         es;
        logic [31:0] ed;
        do_reset();
        for (int i = 0; i < 4; i++) begin acc[i] = 0; gcnt[i] = 0; in_dest[i] = 2'd0; end
        g = 0;
        out_ready = 4'hF;
        in_valid  = 4'hF;
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < 4; i++) in_data[i] = 32'(i * 256 + acc[i]);
            rdy = in_ready;
            tick();
            for (int i = 0; i < 4; i++) if (rdy[i]) acc[i]++;
            if (c >= 1) begin
                es = g % 4;
                ed = 32'(es * 256 + gcnt[es]);
                n_checks++; if (out_valid !== 4'b0001) $display("FAIL fair_valid c=%0d: got %h want 1", c, out_valid); else n_pass++;
                n_checks++; if (out_src[0] !== 2'(es)) $display("FAIL fair_src c=%0d: got %0d want %0d", c, out_src[0], es); else n_pass++;
                n_checks++; if (out_data[0] !== ed) $display("FAIL fair_data c=%0d: got %h want %h", c, out_data[0], ed); else n_pass++;
                gcnt[es]++;
                g++;
            end
        end
        in_valid = '0;
    endtask

    task automatic test_permutation;
        logic [31:0] ed;
        do_reset();
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) in_dest[i] = 2'(3 - i);
        in_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 4; i++) in_data[i] = 32'(i * 256 + c);
            #1;
            n_checks++; if (stall !== 1'b0) $display("FAIL perm_stall c=%0d: got %b want 0", c, stall); else n_pass++;
            tick();
            if (c == 0) begin
                n_checks++; if (out_valid !== 4'h0) $display("FAIL perm_first: got %h want 0", out_valid); else n_pass++;
            end else begin
                n_checks++; if (out_valid !== 4'hF) $display("FAIL perm_valid c=%0d: got %h want f", c, out_valid); else n_pass++;
                for (int j = 0; j < 4; j++) begin
                    ed = 32'((3 - j) * 256 + (c - 1));
                    n_checks++; if (out_data[j] !== ed) $display("FAIL perm_data c=%0d j=%0d: got %h want %h", c, j, out_data[j], ed); else n_pass++;
                    n_checks++; if (out_src[j] !== 2'(3 - j)) $display("FAIL perm_src c=%0d j=%0d: got %0d want %0d", c, j, out_src[j], 3 - j); else n_pass++;
                end
            end
        end
        in_valid = '0;
        tick(); tick();
        n_checks++; if (out_valid !== 4'h0) $display("FAIL perm_drained: got %h want 0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic rdy;
        int   acc0;
        do_reset();
        acc0 = 0;
        out_ready = 4'b1110;
        in_dest[0] = 2'd0;
        in_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            in_data[0] = 32'h100 + 32'(acc0);
            rdy = in_ready[0];
            tick();
            if (rdy) acc0++;
            if (c == 2) begin
                n_checks++; if (in_ready[0] !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready[0]); else n_pass++;
                n_checks++; if (stall !== 1'b1) $display("FAIL bp_stall: got %b want 1", stall); else n_pass++;
            end
        end
        n_checks++; if (acc0 !== 3) $display("FAIL bp_accepts: got %0d want 3", acc0); else n_pass++;
        n_checks++; if (out_valid !== 4'b0001) $display("FAIL bp_hold_valid: got %h want 1", out_valid); else n_pass++;
        n_checks++; if (out_data[0] !== 32'h100) $display("FAIL bp_hold_data: got %h want 100", out_data[0]); else n_pass++;
        in_valid = '0;
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL bp_stall_release: got %b want 0", stall); else n_pass++;
        out_ready = 4'hF;
        for (int k = 1; k < 3; k++) begin
            tick();
            n_checks++; if (out_valid !== 4'b0001) $display("FAIL bp_drain_valid k=%0d: got %h want 1", k, out_valid); else n_pass++;
            n_checks++; if (out_data[0] !== 32'h100 + 32'(k)) $display("FAIL bp_drain_data k=%0d: got %h want %h", k, out_data[0], 32'h100 + 32'(k)); else n_pass++;
        end
        tick();
        n_checks++; if (out_valid !== 4'h0) $display("FAIL bp_no_dup: got %h want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 4'hF) $display("FAIL bp_ready_back: got %h want f", in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        out_ready = 4'h0;
        in_dest[2] = 2'd2; in_dest[3] = 2'd2;
        in_data[2] = 32'h222; in_data[3] = 32'h333;
        in_valid = 4'b1100;
        tick(); tick(); tick();
        n_checks++; if (out_valid !== 4'b0100 || out_src[2] !== 2'd2) $display("FAIL mid_pre: got valid %h src %0d want 4/2", out_valid, out_src[2]); else n_pass++;
        n_checks++; if (in_ready !== 4'b0011) $display("FAIL mid_pre_ready: got %h want 3", in_ready); else n_pass++;
        in_valid = '0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        n_checks++; if (out_valid !== 4'h0) $display("FAIL mid_out_valid: got %h want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 4'hF) $display("FAIL mid_in_ready: got %h want f", in_ready); else n_pass++;
        out_ready = 4'hF;
        in_dest[1] = 2'd2; in_dest[3] = 2'd2;
        in_data[1] = 32'hA1; in_data[3] = 32'hA3;
        in_valid = 4'b1010;
        tick();
        in_valid = '0;
        tick();
        n_checks++; if (out_valid !== 4'b0100) $display("FAIL mid_first_valid: got %h want 4", out_valid); else n_pass++;
        n_checks++; if (out_src[2] !== 2'd1 || out_data[2] !== 32'hA1) $display("FAIL mid_first_grant: got src %0d data %h want 1/a1", out_src[2], out_data[2]); else n_pass++;
        tick();
        n_checks++; if (out_src[2] !== 2'd3 || out_data[2] !== 32'hA3) $display("FAIL mid_second_grant: got src %0d data %h want 3/a3", out_src[2], out_data[2]); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 4'h0) $display("FAIL mid_no_stale: got %h want 0", out_valid); else n_pass++;
    endtask

    task automatic test_invalid_dest;
        b_out_ready = 3'b111;
        b_in_data[0] = 32'h600D; b_in_dest[0] = 2'd2;
        b_in_data[1] = 32'hBAD;  b_in_dest[1] = 2'd3;
        b_in_valid = 4'b0011;
        tick();
        b_in_valid = '0;
        n_checks++; if (b_dest_err !== 1'b0) $display("FAIL inv_err_early: got %b want 0", b_dest_err); else n_pass++;
        tick();
        n_checks++; if (b_dest_err !== 1'b1) $display("FAIL inv_err_set: got %b want 1", b_dest_err); else n_pass++;
        n_checks++; if (b_out_valid !== 3'b100) $display("FAIL inv_valid: got %b want 100", b_out_valid); else n_pass++;
        n_checks++; if (b_out_data[2] !== 32'h600D || b_out_src[2] !== 2'd0) $display("FAIL inv_good_word: got %h src %0d want 600d/0", b_out_data[2], b_out_src[2]); else n_pass++;
        n_checks++; if (b_in_ready !== 4'hF) $display("FAIL inv_dropped: got %h want f", b_in_ready); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (b_out_valid !== 3'b000) $display("FAIL inv_never_out c=%0d: got %b want 000", c, b_out_valid); else n_pass++;
            n_checks++; if (b_dest_err !== 1'b1) $display("FAIL inv_sticky c=%0d: got %b want 1", c, b_dest_err); else n_pass++;
        end
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        n_checks++; if (b_dest_err !== 1'b0) $display("FAIL inv_err_cleared: got %b want 0", b_dest_err); else n_pass++;
    endtask

    initial begin
        RST = 1'b1; b_rst = 1'b1;
        in_valid = '0; in_data = '0; in_dest = '0; out_ready = '0;
        b_in_valid = '0; b_in_data = '0; b_in_dest = '0; b_out_ready = '0;
        test_reset();
        test_single_path();
        test_fairness();
        test_permutation();
        test_backpressure();
        test_reset_mid();
        test_invalid_dest();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
